// File: rtl/ssp_tx_fifo.sv
// SSP transmit FIFO: 4 x 8-bit circular buffer written from the APB side and drained by the serial transmitter.
// Optional sticky overflow flag is built only when SSP_TXFIFO_OVF_EN is defined.
module ssp_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       PCLK,
  input  logic       CLEAR_B,
  input  logic       PSEL,
  input  logic       PWRITE,
  input  logic [7:0] PWDATA,
  input  logic       transmit_complete,
  output logic [7:0] TxData,
  output logic       tx_ready,
  output logic       SSPTXINTR,
  output logic [2:0] tx_count,
  output logic       tx_overflow
);

  localparam logic [2:0] FULL_COUNT = 3'(DEPTH);

  logic [7:0] mem [DEPTH];
  logic [1:0] wr_ptr_reg, wr_ptr_next;
  logic [1:0] rd_ptr_reg, rd_ptr_next;
  logic [2:0] count_reg, count_next;
  logic       tc_q_reg;

  logic       full;
  logic       push;
  logic       pop;
  logic [1:0] rd_ptr_inc;

  assign full       = (count_reg == FULL_COUNT);
  assign push       = PSEL && PWRITE && !full;
  // Rising edge of transmit_complete means the transmitter has consumed the head word.
  assign pop        = !tc_q_reg && transmit_complete && (count_reg != 3'd0);
  assign rd_ptr_inc = rd_ptr_reg + 2'd1;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + 2'd1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_inc;
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + 3'd1;
      2'b01:   count_next = count_reg - 3'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      wr_ptr_reg <= 2'd0;
      rd_ptr_reg <= 2'd0;
      count_reg  <= 3'd0;
      tc_q_reg   <= 1'b1;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      tc_q_reg   <= transmit_complete;
    end
  end

  // Storage is deliberately not reset; contents are meaningless while count is zero.
  always_ff @(posedge PCLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= PWDATA;
    end
  end

  // Look ahead one entry during a pop so the transmitter never restarts on the word it just sent.
  assign TxData    = pop ? mem[rd_ptr_inc] : mem[rd_ptr_reg];
  assign tx_ready  = pop ? (count_reg >= 3'd2) : (count_reg != 3'd0);
  assign SSPTXINTR = full;
  assign tx_count  = count_reg;

`ifdef SSP_TXFIFO_OVF_EN
  logic drop;
  logic ovf_reg;

  assign drop = PSEL && PWRITE && full;

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      ovf_reg <= 1'b0;
    end else if (drop) begin
      ovf_reg <= 1'b1;
    end
  end

  assign tx_overflow = ovf_reg;
`else
  assign tx_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ssp_tx_fifo.sv
// Self-checking bench for ssp_tx_fifo: queue-based reference model, per-cycle compare, directed scenarios and random traffic.
module tb_ssp_tx_fifo;

  logic       PCLK;
  logic       CLEAR_B;
  logic       PSEL;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic       transmit_complete;
  logic [7:0] TxData;
  logic       tx_ready;
  logic       SSPTXINTR;
  logic [2:0] tx_count;
  logic       tx_overflow;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: FIFO contents as a queue, last sampled transmit_complete, sticky overflow.
  logic [7:0] q[$];
  logic       tc_prev;
  logic       ovf;

  ssp_tx_fifo #(.DEPTH(4)) dut (
    .PCLK              (PCLK),
    .CLEAR_B           (CLEAR_B),
    .PSEL              (PSEL),
    .PWRITE            (PWRITE),
    .PWDATA            (PWDATA),
    .transmit_complete (transmit_complete),
    .TxData            (TxData),
    .tx_ready          (tx_ready),
    .SSPTXINTR         (SSPTXINTR),
    .tx_count          (tx_count),
    .tx_overflow       (tx_overflow)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    tc_prev = 1'b1;
    ovf     = 1'b0;
  endtask

  task automatic model_update();
    bit is_full, do_pop, do_push;
    if (!CLEAR_B) begin
      model_reset();
      return;
    end
    is_full = (q.size() == 4);
    do_pop  = !tc_prev && transmit_complete && (q.size() != 0);
    do_push = PSEL && PWRITE && !is_full;
    if (PSEL && PWRITE && is_full) ovf = 1'b1;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(PWDATA);
    tc_prev = transmit_complete;
  endtask

  // One bus cycle: commit the previous cycle into the model, drive new inputs, stop at the sampling edge.
  task automatic cyc(input logic s, input logic w, input logic [7:0] d, input logic tc, input logic clr);
    @(posedge PCLK);
    model_update();
    #1;
    PSEL              = s;
    PWRITE            = w;
    PWDATA            = d;
    transmit_complete = tc;
    CLEAR_B           = clr;
    if (!clr) model_reset();
    @(negedge PCLK);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("rst_tx_ready", int'(tx_ready), 0);
    chk("rst_tx_count", int'(tx_count), 0);
    chk("rst_intr", int'(SSPTXINTR), 0);
    chk("rst_ovf", int'(tx_overflow), 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  always @(negedge PCLK) begin
    bit         m_pop;
    bit         exp_rdy;
    logic [7:0] exp_d;
    if (chk_en) begin
      m_pop   = CLEAR_B && !tc_prev && transmit_complete && (q.size() != 0);
      exp_rdy = m_pop ? (q.size() >= 2) : (q.size() != 0);
      exp_d   = 8'h00;
      if (m_pop && q.size() >= 2) exp_d = q[1];
      else if (!m_pop && q.size() != 0) exp_d = q[0];
      chk("m_tx_ready", int'(tx_ready), int'(exp_rdy));
      chk("m_tx_count", int'(tx_count), q.size());
      chk("m_intr", int'(SSPTXINTR), int'(q.size() == 4));
`ifdef SSP_TXFIFO_OVF_EN
      chk("m_ovf", int'(tx_overflow), int'(ovf));
`else
      chk("m_ovf", int'(tx_overflow), 0);
`endif
      if (exp_rdy) chk("m_txdata", int'(TxData), int'(exp_d));
    end
  end

  initial begin
    logic [7:0] vals [4];
    bit         tc_r;
    int         rate;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    CLEAR_B = 1'b0; PSEL = 1'b0; PWRITE = 1'b0; PWDATA = 8'h00; transmit_complete = 1'b1;
    model_reset();
    chk_en = 1'b1;

    // Single push becomes visible on the next cycle.
    do_reset();
    cyc(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("s1_ready", int'(tx_ready), 1);
    chk("s1_data", int'(TxData), 8'hA5);
    chk("s1_count", int'(tx_count), 1);

    // Fill, then a dropped fifth write.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, vals[i], 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
    chk("s2_intr", int'(SSPTXINTR), 1);
    chk("s2_count", int'(tx_count), 4);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("s2_count_after", int'(tx_count), 4);
    chk("s2_head", int'(TxData), 8'h11);
`ifdef SSP_TXFIFO_OVF_EN
    chk("s2_ovf", int'(tx_overflow), 1);
`else
    chk("s2_ovf", int'(tx_overflow), 0);
`endif

    // Head stays stable while transmitter is busy; look-ahead on the rise.
    do_reset();
    cyc(1'b1, 1'b1, 8'h11, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("s3_hold", int'(TxData), 8'h11);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("s3_rise_data", int'(TxData), 8'h22);
    chk("s3_rise_ready", int'(tx_ready), 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("s3_count", int'(tx_count), 1);

    // Last word popped: tx_ready drops in the pop cycle.
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("s4_ready", int'(tx_ready), 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("s4_count", int'(tx_count), 0);

    // Push while full coincident with pop is dropped; pointers wrap.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, vals[i], 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 8'h66, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("s5_count", int'(tx_count), 3);
    chk("s5_head", int'(TxData), 8'h22);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    end
    cyc(1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("s5_wrap_data", int'(TxData), 8'h77);
    chk("s5_wrap_count", int'(tx_count), 1);

    // Reset mid-transfer discards everything; a later rise is ignored.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, vals[i], 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("s6_rst_count", int'(tx_count), 0);
    chk("s6_rst_ready", int'(tx_ready), 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("s6_rise_ready", int'(tx_ready), 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("s6_count", int'(tx_count), 0);

    // Random traffic with varying write pressure and occasional resets.
    tc_r = 1'b1;
    rate = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) rate = $urandom_range(10, 90);
      if ($urandom_range(0, 3) == 0) tc_r = ~tc_r;
      cyc(($urandom_range(0, 99) < rate), ($urandom_range(0, 3) != 0), 8'($urandom),
          tc_r, ($urandom_range(0, 199) != 0));
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
